// File: rtl/uart_pkg.sv
// Shared UART definitions: frame header, parser state encoding, error codes
// and the bit-period arithmetic used by both the receiver and the frame parser.
package uart_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hAA;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
    localparam logic [1:0] ERR_BAD_CSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic int bit_period(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Running frame checksum: plain modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte silence counter; pulses expired for one cycle when THRESH
// consecutive enabled, uncleared cycles have elapsed.
module uart_idle_timer
    import uart_pkg::*;
#(
    parameter int THRESH = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(THRESH + 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic             expired_r;

    // Count silent busy cycles; saturate at the threshold so the count never wraps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_r     <= ZERO_C;
            expired_r <= 1'b0;
        end else if (clear) begin
            cnt_r     <= ZERO_C;
            expired_r <= 1'b0;
        end else if (enable) begin
            expired_r <= (cnt_r == LAST_C);
            if (cnt_r != THRESH_C) begin
                cnt_r <= cnt_r + ONE_C;
            end
        end else begin
            expired_r <= 1'b0;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/uart_frame_parser.sv
// Parses AA|CMD|LEN|PAYLOAD|CSUM frames from the UART byte strobe, streams
// payload bytes, and reports frame completion or a classified abort.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int UART_BPS      = 9600,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_CHARS = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] in_data,
    input  logic       in_flag,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic [7:0] pay_idx,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_len,
    output logic       busy
);

    localparam int         THRESH    = TIMEOUT_CHARS * 10 * bit_period(CLK_FREQ, UART_BPS);
    localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [7:0] cmd_r;
    logic [7:0] len_r;
    logic [7:0] sum_r;
    logic [7:0] rem_r;
    logic [7:0] idx_r;
    logic [7:0] pay_data_r;
    logic       pay_valid_r;
    logic [7:0] pay_idx_r;
    logic       frame_ok_r;
    logic       frame_err_r;
    logic [1:0] err_code_r;
    logic [7:0] frame_cmd_r;
    logic [7:0] frame_len_r;
    logic       busy_r;
    logic       in_idle_s;
    logic       timer_clear_s;
    logic       expired_s;

    assign in_idle_s     = (state_r == ST_IDLE);
    assign timer_clear_s = in_flag | in_idle_s;

    uart_idle_timer #(
        .THRESH (THRESH)
    ) u_idle_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (timer_clear_s),
        .enable  (~in_idle_s),
        .expired (expired_s)
    );

    // Next-state selection; a byte strobe always takes priority over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        if (in_flag) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_data == HEADER_BYTE) begin
                        state_nxt_s = ST_CMD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CMD: state_nxt_s = ST_LEN;
                ST_LEN: begin
                    if (in_data > MAX_LEN_C) begin
                        state_nxt_s = ST_IDLE;
                    end else if (in_data == 8'd0) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (rem_r == 8'd1) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end
                ST_CSUM: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end else if (expired_s && !in_idle_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame datapath and registered outputs; strobes default low every cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            cmd_r       <= 8'd0;
            len_r       <= 8'd0;
            sum_r       <= 8'd0;
            rem_r       <= 8'd0;
            idx_r       <= 8'd0;
            pay_data_r  <= 8'd0;
            pay_valid_r <= 1'b0;
            pay_idx_r   <= 8'd0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            frame_cmd_r <= 8'd0;
            frame_len_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            pay_valid_r <= 1'b0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (in_flag) begin
                case (state_r)
                    ST_CMD: begin
                        cmd_r <= in_data;
                        sum_r <= in_data;
                    end
                    ST_LEN: begin
                        len_r <= in_data;
                        sum_r <= csum_add(sum_r, in_data);
                        rem_r <= in_data;
                        idx_r <= 8'd0;
                        if (in_data > MAX_LEN_C) begin
                            frame_err_r <= 1'b1;
                            err_code_r  <= ERR_BAD_LEN;
                        end
                    end
                    ST_PAYLOAD: begin
                        pay_data_r  <= in_data;
                        pay_idx_r   <= idx_r;
                        pay_valid_r <= 1'b1;
                        sum_r       <= csum_add(sum_r, in_data);
                        idx_r       <= idx_r + 8'd1;
                        rem_r       <= rem_r - 8'd1;
                    end
                    ST_CSUM: begin
                        if (in_data == sum_r) begin
                            frame_ok_r  <= 1'b1;
                            frame_cmd_r <= cmd_r;
                            frame_len_r <= len_r;
                        end else begin
                            frame_err_r <= 1'b1;
                            err_code_r  <= ERR_BAD_CSUM;
                        end
                    end
                    default: begin
                        sum_r <= sum_r;
                    end
                endcase
            end else if (expired_s && !in_idle_s) begin
                frame_err_r <= 1'b1;
                err_code_r  <= ERR_TIMEOUT;
            end
        end
    end

    assign pay_data  = pay_data_r;
    assign pay_valid = pay_valid_r;
    assign pay_idx   = pay_idx_r;
    assign frame_ok  = frame_ok_r;
    assign frame_err = frame_err_r;
    assign err_code  = err_code_r;
    assign frame_cmd = frame_cmd_r;
    assign frame_len = frame_len_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: a fixed vector table, directed corner sequences
// and random frames, all checked cycle by cycle against a frame-buffer model.
module tb_uart_frame_parser;

    localparam int CLK_FREQ      = 100_000;
    localparam int UART_BPS      = 10_000;
    localparam int MAX_LEN       = 16;
    localparam int TIMEOUT_CHARS = 3;
    localparam int THRESH        = TIMEOUT_CHARS * 10 * (CLK_FREQ / UART_BPS);

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] in_data;
    logic       in_flag;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic [7:0] pay_idx;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       busy;

    uart_frame_parser #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BPS      (UART_BPS),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_CHARS (TIMEOUT_CHARS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_data   (in_data),
        .in_flag   (in_flag),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_idx   (pay_idx),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cmd (frame_cmd),
        .frame_len (frame_len),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the bytes of the frame in progress, plus silence count.
    logic [7:0] q[$];
    int         silence;
    logic [7:0] e_pd, e_pi, e_cmd, e_len;
    logic       e_pv, e_ok, e_err, e_busy;
    logic [1:0] e_code;

    typedef struct {
        logic       f;
        logic [7:0] d;
        logic [7:0] pd;
        logic       pv;
        logic [7:0] pi;
        logic       ok;
        logic       err;
        logic [1:0] code;
        logic [7:0] cmd;
        logic [7:0] len;
        logic       busy;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [37:0] pk(input logic [7:0] pd, input logic pv, input logic [7:0] pi,
                                       input logic ok, input logic err, input logic [1:0] code,
                                       input logic [7:0] cmd, input logic [7:0] len, input logic bz);
        return {pd, pv, pi, ok, err, code, cmd, len, bz};
    endfunction

    function automatic logic [37:0] dut_vec();
        return pk(pay_data, pay_valid, pay_idx, frame_ok, frame_err, err_code, frame_cmd, frame_len, busy);
    endfunction

    task automatic model_reset();
        q.delete();
        silence = 0;
        e_pd = 8'h00; e_pi = 8'h00; e_cmd = 8'h00; e_len = 8'h00;
        e_pv = 1'b0; e_ok = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_code = 2'd0;
    endtask

    task automatic model_edge(input logic f, input logic [7:0] d);
        int n;
        int s;
        e_pv = 1'b0; e_ok = 1'b0; e_err = 1'b0;
        if (f) begin
            silence = 0;
            if (q.size() == 0) begin
                if (d == 8'hAA) q.push_back(d);
            end else begin
                q.push_back(d);
                n = q.size();
                if (n == 3) begin
                    if (int'(d) > MAX_LEN) begin
                        e_err = 1'b1; e_code = 2'd1; q.delete();
                    end
                end else if (n == int'(q[2]) + 4) begin
                    s = 0;
                    for (int i = 1; i <= n - 2; i++) s = s + int'(q[i]);
                    if ((s % 256) == int'(d)) begin
                        e_ok = 1'b1; e_cmd = q[1]; e_len = q[2];
                    end else begin
                        e_err = 1'b1; e_code = 2'd2;
                    end
                    q.delete();
                end else if (n >= 4) begin
                    e_pv = 1'b1; e_pd = d; e_pi = 8'(n - 4);
                end
            end
        end else if (q.size() > 0) begin
            silence++;
            if (silence == THRESH + 1) begin
                e_err = 1'b1; e_code = 2'd3; q.delete();
            end
        end
        e_busy = (q.size() > 0);
    endtask

    task automatic check_vec(input string nm, input logic [37:0] exp_v);
        logic [37:0] got_v;
        got_v = dut_vec();
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got_v, exp_v);
        end
    endtask

    task automatic check_model(input string nm);
        check_vec(nm, pk(e_pd, e_pv, e_pi, e_ok, e_err, e_code, e_cmd, e_len, e_busy));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
    task automatic step(input logic f, input logic [7:0] d, input string nm);
        in_flag = f;
        in_data = d;
        @(posedge sys_clk);
        model_edge(f, d);
        @(negedge sys_clk);
        check_model(nm);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), nm);
    endtask

    task automatic send(input logic [7:0] b[$], input string nm);
        for (int i = 0; i < b.size(); i++) step(1'b1, b[i], nm);
    endtask

    task automatic rgap();
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), "rnd_gap");
    endtask

    logic [7:0] fb[$];
    int         first_err;
    int         mode;
    int         len;
    int         keep;
    logic [7:0] sum;
    logic [7:0] bt;

    initial begin
        tbl[0] = '{1'b1, 8'hAA, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[2] = '{1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 8'h20, 8'h20, 1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 8'h33, 8'h20, 1'b0, 8'h01, 1'b1, 1'b0, 2'd0, 8'h01, 8'h02, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 8'h20, 1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 8'h01, 8'h02, 1'b0};

        sys_rst = 1'b1;
        in_flag = 1'b0;
        in_data = 8'h00;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_vec("reset_state", 38'd0);
        sys_rst = 1'b0;

        // Good frame AA 01 02 10 20 33 from the vector table.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].f, tbl[i].d, "tbl_model");
            check_vec("tbl_vec", pk(tbl[i].pd, tbl[i].pv, tbl[i].pi, tbl[i].ok, tbl[i].err,
                                     tbl[i].code, tbl[i].cmd, tbl[i].len, tbl[i].busy));
        end

        // Garbage prefix then zero-length frame.
        fb = {8'h55, 8'h00, 8'hAA, 8'h7F, 8'h00, 8'h7F};
        send(fb, "zero_len");
        check_vec("zero_len_cmd", pk(pay_data, pay_valid, pay_idx, 1'b1, 1'b0, err_code, 8'h7F, 8'h00, 1'b0));
        idle(2, "zero_len_idle");

        // Bad checksum.
        fb = {8'hAA, 8'h01, 8'h01, 8'h05, 8'h00};
        send(fb, "bad_csum");
        total++;
        if (!(frame_err === 1'b1 && err_code === 2'd2)) begin
            bad++;
            $display("FAIL bad_csum_code got err=%b code=%0d expected err=1 code=2", frame_err, err_code);
        end
        idle(2, "bad_csum_idle");

        // Bad length, then a good frame.
        fb = {8'hAA, 8'h01, 8'h11};
        send(fb, "bad_len");
        total++;
        if (!(frame_err === 1'b1 && err_code === 2'd1 && busy === 1'b0)) begin
            bad++;
            $display("FAIL bad_len_code got err=%b code=%0d busy=%b expected 1/1/0", frame_err, err_code, busy);
        end
        fb = {8'hAA, 8'h05, 8'h01, 8'h09, 8'h0F};
        send(fb, "after_bad_len");

        // Timeout: error must appear exactly THRESH+1 cycles after the last byte.
        fb = {8'hAA, 8'h01, 8'h03, 8'h10};
        send(fb, "tmo_pre");
        first_err = 0;
        for (int k = 1; k <= THRESH + 5; k++) begin
            step(1'b0, 8'h00, "tmo_wait");
            if (frame_err === 1'b1 && first_err == 0) first_err = k;
        end
        total++;
        if (first_err != THRESH + 1 || err_code !== 2'd3) begin
            bad++;
            $display("FAIL tmo_latency got=%0d code=%0d expected=%0d code=3", first_err, err_code, THRESH + 1);
        end
        fb = {8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send(fb, "tmo_recover");

        // Byte lands on the threshold cycle: no error, frame completes.
        fb = {8'hAA, 8'h01, 8'h03, 8'h10};
        send(fb, "edge_pre");
        idle(THRESH, "edge_wait");
        fb = {8'h20, 8'h30, 8'h64};
        send(fb, "edge_byte");
        total++;
        if (frame_ok !== 1'b1 || frame_len !== 8'h03) begin
            bad++;
            $display("FAIL edge_ok got ok=%b len=%h expected ok=1 len=03", frame_ok, frame_len);
        end

        // Reset mid-payload.
        fb = {8'hAA, 8'h02, 8'h03, 8'h11};
        send(fb, "rst_pre");
        sys_rst = 1'b1;
        in_flag = 1'b0;
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_vec("rst_mid", 38'd0);
        sys_rst = 1'b0;
        fb = {8'hAA, 8'h02, 8'h00, 8'h02};
        send(fb, "rst_after");
        total++;
        if (frame_ok !== 1'b1 || frame_cmd !== 8'h02) begin
            bad++;
            $display("FAIL rst_after_ok got ok=%b cmd=%h expected ok=1 cmd=02", frame_ok, frame_cmd);
        end

        // Random frames: good, corrupted, bad length, truncated, garbage.
        for (int it = 0; it < 250; it++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                bt = 8'($urandom_range(0, 255));
                if (bt == 8'hAA) bt = 8'h55;
                step(1'b1, bt, "rnd_garbage");
            end else if (mode == 1) begin
                step(1'b1, 8'hAA, "rnd_badlen");
                step(1'b1, 8'($urandom_range(0, 255)), "rnd_badlen");
                step(1'b1, 8'($urandom_range(MAX_LEN + 1, 255)), "rnd_badlen");
            end else begin
                len = $urandom_range(0, MAX_LEN);
                keep = (mode == 2 && len > 0) ? $urandom_range(0, len - 1) : len;
                bt = 8'($urandom_range(0, 255));
                step(1'b1, 8'hAA, "rnd_frame");
                rgap();
                step(1'b1, bt, "rnd_frame");
                sum = bt + 8'(len);
                rgap();
                step(1'b1, 8'(len), "rnd_frame");
                for (int j = 0; j < keep; j++) begin
                    rgap();
                    bt = 8'($urandom_range(0, 255));
                    sum = sum + bt;
                    step(1'b1, bt, "rnd_payload");
                end
                if (mode == 2 && len > 0) begin
                    idle(THRESH + 2, "rnd_trunc");
                end else begin
                    rgap();
                    if (mode == 3) sum = sum ^ 8'(1 << $urandom_range(0, 7));
                    step(1'b1, sum, "rnd_csum");
                end
            end
            rgap();
        end

        idle(3, "final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
